// File: rtl/flash_writer_pkg.sv
// Shared types, command codes and status-register bit positions for the flash writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flash_writer_pkg;

  typedef logic [15:0] flash_bus_t;
  typedef logic [22:0] flash_addr_t;

  // Device command codes
  localparam flash_bus_t CMD_PROGRAM    = 16'h0040;
  localparam flash_bus_t CMD_ERASE      = 16'h0020;
  localparam flash_bus_t CMD_CONFIRM    = 16'h00D0;
  localparam flash_bus_t CMD_CLR_STATUS = 16'h0050;
  localparam flash_bus_t CMD_READ_ARRAY = 16'h00FF;
  localparam flash_bus_t CMD_READ_SR    = 16'h0070;

  // Status register bit positions
  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCK_ERR  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_POLL, S_CHECK, S_CLRSR, S_RESTORE, S_DONE
  } fw_state_t;

  typedef enum logic [2:0] {
    B_IDLE, B_SETUP, B_PULSE, B_HOLD, B_RPULSE, B_RREC
  } bus_state_t;

endpackage

// File: rtl/flash_writer_bus_cycle.sv
// One flash bus cycle: write (setup, WE# pulse, hold) or read (OE# pulse, sample, recovery).
// Latency: write SETUP_CYC+PULSE_CYC+1 cycles, read PULSE_CYC+1 cycles; done pulses in the last one.
// Backpressure: start is only taken in idle; caller holds start until done.
module flash_bus_cycle
  import flash_writer_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_write,
  input  flash_addr_t addr,
  input  flash_bus_t  wdata,
  output logic        done,
  output flash_bus_t  rdata,
  output flash_addr_t bus_addr,
  output flash_bus_t  bus_wdata,
  output logic        bus_drive,
  output logic        we_n,
  output logic        oe_n,
  input  flash_bus_t  bus_rdata
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);

  bus_state_t state, nxt;
  logic [7:0] cnt;

  // State register; phase counter restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= B_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= nxt;
      cnt   <= (state != nxt) ? 8'd0 : cnt + 8'd1;
    end
  end

  // Next state and strobe decode; strobes derive only from the registered state
  always_comb begin
    nxt       = state;
    done      = 1'b0;
    we_n      = 1'b1;
    oe_n      = 1'b1;
    bus_drive = 1'b0;
    case (state)
      B_IDLE:   if (start) nxt = is_write ? B_SETUP : B_RPULSE;
      B_SETUP: begin
        bus_drive = 1'b1;
        if (cnt == SETUP_LAST) nxt = B_PULSE;
      end
      B_PULSE: begin
        bus_drive = 1'b1;
        we_n      = 1'b0;
        if (cnt == PULSE_LAST) nxt = B_HOLD;
      end
      B_HOLD: begin
        bus_drive = 1'b1;
        done      = 1'b1;
        nxt       = B_IDLE;
      end
      B_RPULSE: begin
        oe_n = 1'b0;
        if (cnt == PULSE_LAST) nxt = B_RREC;
      end
      B_RREC: begin
        done = 1'b1;
        nxt  = B_IDLE;
      end
      default:  nxt = B_IDLE;
    endcase
  end

  // Capture address/data at start; sample the bus on the last OE# cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state == B_IDLE && start) begin
        bus_addr  <= addr;
        bus_wdata <= wdata;
      end
      if (state == B_RPULSE && cnt == PULSE_LAST) rdata <= bus_rdata;
    end
  end

endmodule

// File: rtl/flash_writer.sv
// Programs a 32-bit word (two 16-bit halves) or erases a block, polling status until ready.
// Latency: data-dependent; several bus cycles plus status polls, ends with read-array restore.
// Backpressure: ce_i is a level held until ready_o; changes to operands after acceptance are ignored.
module flash_writer
  import flash_writer_pkg::*;
#(
  parameter int          SETUP_CYC  = 2,
  parameter int          PULSE_CYC  = 4,
  parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        op_i,
  input  logic [22:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic        err_o,
  output logic [22:0] flash_addr_o,
  inout  wire  [15:0] flash_data,
  output logic        flash_ce_o,
  output logic        flash_oe_o,
  output logic        flash_we_o,
  output logic        flash_byte_o,
  output logic        flash_vpen_o,
  output logic        flash_rp_o,
  output logic        flash_ce1_o,
  output logic        flash_ce2_o
);

  fw_state_t   state, nxt;
  logic        op_r, step_r, half_r, err_r;
  logic [22:0] addr_r;
  logic [31:0] data_r;
  logic [23:0] poll_cnt;
  flash_bus_t  sr_r;

  logic        start, is_write, done, bus_drive;
  flash_bus_t  cmd_word, rdata, bus_wdata;
  flash_addr_t op_addr;
  logic        sr_ready, sr_bad, timeout;
  logic        unused_bits;

  // Erase targets the 128 KiB block base; program targets the current 16-bit half
  assign op_addr  = op_r ? {addr_r[22:17], 17'b0} : {addr_r[22:2], half_r, 1'b0};
  assign sr_ready = sr_r[SR_READY];
  assign sr_bad   = sr_r[SR_ERASE_ERR] | sr_r[SR_PROG_ERR] | sr_r[SR_VPP_ERR] | sr_r[SR_LOCK_ERR];
  assign timeout  = (poll_cnt >= POLL_LIMIT);
  assign unused_bits = ^{addr_r[1:0], sr_r[15:8], sr_r[6], sr_r[2], sr_r[0]};

  assign flash_data   = bus_drive ? bus_wdata : 16'hzzzz;
  assign flash_byte_o = 1'b1;
  assign flash_vpen_o = 1'b1;
  assign flash_rp_o   = 1'b1;
  assign flash_ce1_o  = 1'b0;
  assign flash_ce2_o  = 1'b0;

  flash_bus_cycle #(.SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC)) u_bus (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_write  (is_write),
    .addr      (op_addr),
    .wdata     (cmd_word),
    .done      (done),
    .rdata     (rdata),
    .bus_addr  (flash_addr_o),
    .bus_wdata (bus_wdata),
    .bus_drive (bus_drive),
    .we_n      (flash_we_o),
    .oe_n      (flash_oe_o),
    .bus_rdata (flash_data)
  );

  // Sequencer state register; chip enable is held off only while in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      flash_ce_o <= 1'b1;
    end else begin
      state      <= nxt;
      flash_ce_o <= 1'b0;
    end
  end

  // Next state, bus-cycle request and command word selection
  always_comb begin
    nxt      = state;
    start    = 1'b0;
    is_write = 1'b1;
    cmd_word = CMD_READ_ARRAY;
    ready_o  = 1'b0;
    err_o    = 1'b0;
    case (state)
      S_IDLE:  if (ce_i) nxt = S_CMD;
      S_CMD: begin
        start = 1'b1;
        if (!step_r) cmd_word = op_r ? CMD_ERASE : CMD_PROGRAM;
        else         cmd_word = op_r ? CMD_CONFIRM : (half_r ? data_r[31:16] : data_r[15:0]);
        if (done && step_r) nxt = S_POLL;
      end
      S_POLL: begin
        start    = 1'b1;
        is_write = 1'b0;
        if (done) nxt = S_CHECK;
      end
      S_CHECK: begin
        if (sr_ready) begin
          if (sr_bad)                nxt = S_CLRSR;
          else if (!op_r && !half_r) nxt = S_CMD;
          else                       nxt = S_RESTORE;
        end else if (timeout) begin
          nxt = S_CLRSR;
        end else begin
          nxt = S_POLL;
        end
      end
      S_CLRSR: begin
        start    = 1'b1;
        cmd_word = CMD_CLR_STATUS;
        if (done) nxt = S_RESTORE;
      end
      S_RESTORE: begin
        start = 1'b1;
        if (done) nxt = S_DONE;
      end
      S_DONE: begin
        // A requester that already let go never sees ready
        ready_o = ce_i;
        err_o   = ce_i & err_r;
        if (!ce_i) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Operand latch, step/half tracking, poll counter and error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
      step_r   <= 1'b0;
      half_r   <= 1'b0;
      err_r    <= 1'b0;
      poll_cnt <= '0;
      sr_r     <= '0;
    end else begin
      case (state)
        S_IDLE: if (ce_i) begin
          op_r   <= op_i;
          addr_r <= addr_i;
          data_r <= data_i;
          step_r <= 1'b0;
          half_r <= 1'b0;
          err_r  <= 1'b0;
        end
        S_CMD: if (done) begin
          step_r <= ~step_r;
          if (step_r) poll_cnt <= '0;
        end
        S_POLL: if (done) begin
          sr_r     <= rdata;
          poll_cnt <= poll_cnt + 24'd1;
        end
        S_CHECK: begin
          if (sr_ready) begin
            if (sr_bad) err_r <= 1'b1;
            else if (!op_r && !half_r) half_r <= 1'b1;
          end else if (timeout) begin
            err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_writer.sv
// Scoreboard bench for flash_writer: models the status register and checks every bus write.
// Latency: n/a.
// Backpressure: n/a.
module tb_flash_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        op_i = 1'b0;
  logic [22:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        ready_o, err_o;
  logic [22:0] flash_addr_o;
  wire  [15:0] flash_data;
  logic        flash_ce_o, flash_oe_o, flash_we_o;
  logic        flash_byte_o, flash_vpen_o, flash_rp_o, flash_ce1_o, flash_ce2_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [38:0] exp_q[$];
  int          polls_seen = 0;
  int          viol = 0;
  int          poll_base = 0;
  int          ready_after = 0;
  logic [15:0] sr_final = 16'h0000;
  logic [22:0] rd_base = '0;
  logic        we_prev = 1'b1;
  logic        oe_prev = 1'b1;
  logic [15:0] sr_val;
  bit          got;

  flash_writer #(.SETUP_CYC(2), .PULSE_CYC(4), .POLL_LIMIT(24'd16)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .op_i(op_i), .addr_i(addr_i), .data_i(data_i),
    .ready_o(ready_o), .err_o(err_o), .flash_addr_o(flash_addr_o), .flash_data(flash_data),
    .flash_ce_o(flash_ce_o), .flash_oe_o(flash_oe_o), .flash_we_o(flash_we_o),
    .flash_byte_o(flash_byte_o), .flash_vpen_o(flash_vpen_o), .flash_rp_o(flash_rp_o),
    .flash_ce1_o(flash_ce1_o), .flash_ce2_o(flash_ce2_o)
  );

  always #5 clk = ~clk;

  // Flash status model: busy until ready_after polls of this operation have completed
  assign sr_val     = ((polls_seen - poll_base) >= ready_after) ? sr_final : 16'h0000;
  assign flash_data = flash_oe_o ? 16'hzzzz : sr_val;

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Bus monitor: completed writes against the scoreboard, poll addresses, strobe rules
  always @(negedge clk) begin
    if ((!flash_we_o && !flash_oe_o) || (!flash_oe_o && flash_data !== sr_val))
      viol <= viol + 1;
    if (!rst) begin
      if (!we_prev && flash_we_o) begin
        if (exp_q.size() == 0) chk("wr_unexp", 64'(exp_q.size()), 64'd1);
        else chk("wr", 64'({flash_addr_o, flash_data}), 64'(exp_q.pop_front()));
      end
      if (!oe_prev && flash_oe_o) begin
        chk("poll_addr", 64'(flash_addr_o & ~23'h2), 64'(rd_base));
        polls_seen <= polls_seen + 1;
      end
    end
    we_prev <= flash_we_o;
    oe_prev <= flash_oe_o;
  end

  task automatic do_op(input bit op, input logic [22:0] a, input logic [31:0] d,
                       input int rdy, input logic [15:0] srf,
                       input bit exp_err, input int exp_polls, input bit drop);
    logic [22:0] base, hi;
    int pb, vb;
    bit seen, ok;
    @(negedge clk);
    pb = polls_seen;
    vb = viol;
    poll_base   = pb;
    ready_after = rdy;
    sr_final    = srf;
    base = op ? {a[22:17], 17'h0} : {a[22:2], 2'b00};
    hi   = base | 23'h2;
    rd_base = base;
    if (op) begin
      exp_q.push_back({base, 16'h0020});
      exp_q.push_back({base, 16'h00D0});
      if (exp_err) exp_q.push_back({base, 16'h0050});
      exp_q.push_back({base, 16'h00FF});
    end else begin
      exp_q.push_back({base, 16'h0040});
      exp_q.push_back({base, d[15:0]});
      if (exp_err) begin
        exp_q.push_back({base, 16'h0050});
        exp_q.push_back({base, 16'h00FF});
      end else begin
        exp_q.push_back({hi, 16'h0040});
        exp_q.push_back({hi, d[31:16]});
        exp_q.push_back({hi, 16'h00FF});
      end
    end
    op_i = op; addr_i = a; data_i = d; ce_i = 1'b1;
    repeat (3) @(negedge clk);
    op_i = ~op; addr_i = ~a; data_i = ~d;
    if (drop) begin
      repeat (7) @(negedge clk);
      ce_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
        @(negedge clk);
        if (ready_o) seen = 1'b1;
      end
      repeat (5) begin
        @(negedge clk);
        if (ready_o) seen = 1'b1;
      end
      chk("drop_ready", 64'(seen), 64'd0);
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (ready_o) begin ok = 1'b1; break; end
      end
      chk("ready", 64'(ok), 64'd1);
      chk("err", 64'(err_o), 64'(exp_err));
      repeat (3) @(negedge clk);
      chk("ready_hold", 64'(ready_o), 64'd1);
      chk("flash_ce", 64'(flash_ce_o), 64'd0);
      ce_i = 1'b0;
      @(negedge clk);
      chk("ready_clr", 64'(ready_o), 64'd0);
      chk("err_clr", 64'(err_o), 64'd0);
    end
    chk("polls", 64'(polls_seen - pb), 64'(exp_polls));
    chk("pending_wr", 64'(exp_q.size()), 64'd0);
    chk("strobe_rules", 64'(viol - vb), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_we", 64'(flash_we_o), 64'd1);
    chk("rst_oe", 64'(flash_oe_o), 64'd1);
    chk("rst_ce", 64'(flash_ce_o), 64'd1);
    chk("rst_addr", 64'(flash_addr_o), 64'd0);
    chk("rst_drive", 64'(dut.bus_drive), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // op, addr, data, polls-before-ready, final SR, err, total polls, drop ce
    do_op(1'b0, 23'h000104, 32'hDEADBEEF, 0,  16'h0080, 1'b0, 2,  1'b0);
    do_op(1'b1, 23'h023456, 32'h00000000, 9,  16'h0080, 1'b0, 10, 1'b0);
    do_op(1'b0, 23'h000200, 32'h12345678, 0,  16'h0090, 1'b1, 1,  1'b0);
    do_op(1'b0, 23'h7FFFFC, 32'hA5A55A5A, 1000, 16'h0080, 1'b1, 16, 1'b0);
    do_op(1'b1, 23'h1FFFFF, 32'h00000000, 0,  16'h00A2, 1'b1, 1,  1'b0);

    // Reset in the middle of a WE# pulse
    @(negedge clk);
    ready_after = 0; sr_final = 16'h0080; poll_base = polls_seen;
    op_i = 1'b0; addr_i = 23'h000104; data_i = 32'h00000001; ce_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!flash_we_o) begin got = 1'b1; break; end
    end
    chk("we_pulse_seen", 64'(got), 64'd1);
    @(negedge clk);
    rst = 1'b1; ce_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_we", 64'(flash_we_o), 64'd1);
    chk("mid_rst_oe", 64'(flash_oe_o), 64'd1);
    chk("mid_rst_ready", 64'(ready_o), 64'd0);
    chk("mid_rst_drive", 64'(dut.bus_drive), 64'd0);
    chk("mid_rst_ce", 64'(flash_ce_o), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b0, 23'h00ABC8, 32'hCAFEF00D, 0, 16'h0080, 1'b0, 2, 1'b0);
    do_op(1'b0, 23'h000010, 32'h0BADC0DE, 0, 16'h0080, 1'b0, 2, 1'b1);
    do_op(1'b0, 23'h400002, 32'h11112222, 3, 16'h0080, 1'b0, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flash_writer.md
FLASH_WRITER -- requirements
Module: flash_writer

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles of addr/data setup before WE# falls.
REQ-002 Parameter PULSE_CYC, default 4: cycles of WE# low (write) or OE# low before sample (read).
REQ-003 Parameter POLL_LIMIT, default 24'hFFFFFF: maximum status polls before timeout.
REQ-004 Reset is rst, synchronous, active-high; clock is clk.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ce_i  in  1  request level from MMU; held until ready_o.
REQ-008 op_i  in  1  0 = program 32-bit word, 1 = erase block.
REQ-009 addr_i  in  23  byte address.
REQ-010 data_i  in  32  program data.
REQ-011 ready_o  out  1  operation complete.
REQ-012 err_o  out  1  valid with ready_o; 1 = device error or timeout.
REQ-013 flash_addr_o  out  23  flash address.
REQ-014 flash_data  inout  16  flash data bus, Z when not driving.
REQ-015 flash_ce_o, flash_oe_o, flash_we_o  out  1 each  active-low strobes.
REQ-016 flash_byte_o, flash_vpen_o, flash_rp_o  out  1 each  constant 1; flash_ce1_o, flash_ce2_o constant 0.

Function
REQ-017 Bus write cycle: SETUP_CYC cycles WE#=1 with addr and data driven, PULSE_CYC cycles WE#=0, 1 hold cycle WE#=1 still driving, then bus released to Z.
REQ-018 Bus read cycle: bus Z, OE#=0 for PULSE_CYC cycles, sample flash_data on last cycle, then OE#=1 for 1 cycle.
REQ-019 WE# and OE# never low in the same cycle; flash_data never driven while OE#=0.
REQ-020 Operands op_i, addr_i, data_i latched in IDLE when ce_i=1; later changes ignored.
REQ-021 Program: low half data_i[15:0] to {addr[22:2],2'b00}, then high half data_i[31:16] to {addr[22:2],2'b10}; each half = write 0x0040, write data, poll.
REQ-022 Erase: write 0x0020 then 0x00D0 to {addr[22:17],17'b0}, poll.
REQ-023 Poll: repeated read cycles at the operation address until SR[7]=1; poll counter 24 bits, reset per poll phase.
REQ-024 On SR[7]=1, error if any of SR[5], SR[4], SR[3], SR[1] set; error skips remaining half, writes 0x0050 (clear status).
REQ-025 Poll count reaching POLL_LIMIT with SR[7]=0 sets err_o (timeout) and proceeds as error.
REQ-026 Every operation ends with write 0x00FF (read array) before DONE.
REQ-027 States: IDLE, CMD (write cycle), POLL (read cycle), CHECK, CLRSR, RESTORE, DONE; step counter selects next command.
REQ-028 DONE: ready_o=1, err_o valid; held until ce_i=0, then IDLE next cycle with ready_o=0, err_o=0.
REQ-029 ce_i deasserted mid-operation: ignored, sequence completes to DONE, then immediately IDLE since ce_i=0.
REQ-030 flash_ce_o=0 whenever not in reset.

Reset
REQ-031 On rst: state IDLE, ready_o=0, err_o=0, flash_we_o=1, flash_oe_o=1, flash_ce_o=1, flash_data Z, flash_addr_o=0, counters 0.
REQ-032 rst mid-cycle aborts immediately with WE#/OE# returned high on the next edge.

Structure
REQ-033 Command codes (0x0040, 0x0020, 0x00D0, 0x0050, 0x00FF, 0x0070) and SR bit positions defined in defines.v alongside FlashBus/FlashAddrBus.
REQ-034 One sub-module flash_bus_cycle: executes one read or write bus cycle, start/done handshake, returns sampled word.

Verification
REQ-035 Program addr 0x000104 data 0xDEADBEEF, model SR=0x80 on first poll -> writes 0x0040/0xBEEF @0x104, 0x0040/0xDEAD @0x106, 0x00FF; ready_o=1, err_o=0.
REQ-036 Erase addr 0x023456 -> 0x0020, 0x00D0 @0x020000, polls until SR=0x80 after 10 polls, ready_o=1, err_o=0.
REQ-037 Program with low-half SR=0x90 -> no high-half writes, 0x0050 then 0x00FF, err_o=1.
REQ-038 POLL_LIMIT=16, SR stuck 0x00 -> exactly 16 polls, err_o=1, ready_o=1.
REQ-039 rst asserted during WE# pulse -> next edge WE#=1, flash_data Z, ready_o=0; new request afterwards completes normally.
REQ-040 ce_i dropped mid-program -> sequence completes, ready_o stays 0, block returns to IDLE; checker confirms REQ-019 throughout.
